// File: rtl/vga_fb_scheduler.sv
`default_nettype none
// ============================================================================
// vga_fb_scheduler : frame-buffer arbiter, display FWFT prefetch + pixel writer
// Optional macro   : STARVE_GUARD_EN (bounded writer wait)
// Revision         : 1.0
// ============================================================================
module vga_fb_scheduler #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 24,
  parameter int FRAME_PIXELS = 307200,
  parameter int FIFO_DEPTH   = 16,
  parameter int RD_LAT       = 2,
  parameter int STARVE_MAX   = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              frame_start,
  input  logic              pix_ren,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_empty,
  output logic              underflow,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_mem_d [FIFO_DEPTH];
  logic [RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;
  logic                underflow_q, underflow_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                fetch_ok;
  logic                fetch_go;
  logic                wr_go;
  logic                force_wr;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic [CNT_W:0]      credit_used;

`ifdef STARVE_GUARD_EN
  localparam int              SC_W       = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!wr_valid || wr_go) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_wr = (starve_cnt_q == STARVE_LIM) && wr_valid;
`else
  assign force_wr = 1'b0;
`endif

  // Credits cover FIFO occupancy plus every non-stale read still in flight.
  assign fifo_empty  = (fifo_cnt_q == '0);
  assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign fetch_ok    = (state_q == FETCH) && !frame_start && (credit_used < DEPTH_C);
  assign fetch_go    = fetch_ok && !force_wr;
  assign wr_ready    = wr_valid && !fetch_go;
  assign wr_go       = wr_valid && wr_ready;

  assign push = rd_pipe_q[RD_LAT-1] && !frame_start;
  assign pop  = pix_ren && !fifo_empty;

  always_comb begin
    rd_pipe_d    = '0;
    rd_pipe_d[0] = mem_re_q && !frame_start;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1] && !frame_start;
    end
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = mem_rdata;
    end
    if (frame_start) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fifo_cnt_d = '0;
      inflight_d = '0;
    end else begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      inflight_d = inflight_q + CNT_W'(fetch_go) - CNT_W'(push);
    end
    underflow_d = underflow_q || (pix_ren && fifo_empty);
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    if (frame_start) begin
      state_d      = FETCH;
      fetch_addr_d = '0;
    end else if (fetch_go) begin
      fetch_addr_d = fetch_addr_q + ADDR_W'(1);
      if (fetch_addr_q == LAST_ADDR) begin
        state_d = DONE;
      end
    end
  end

  always_comb begin
    mem_re_d    = fetch_go;
    mem_we_d    = wr_go;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (fetch_go) begin
      mem_addr_d = fetch_addr_q;
    end else if (wr_go) begin
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      fifo_cnt_q   <= '0;
      inflight_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_pipe_q    <= '0;
      underflow_q  <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      inflight_q   <= inflight_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_pipe_q    <= rd_pipe_d;
      underflow_q  <= underflow_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= fifo_mem_d[i];
      end
    end
  end

  assign pix_data  = fifo_mem_q[rd_ptr_q];
  assign pix_empty = fifo_empty;
  assign underflow = underflow_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_scheduler.sv
`default_nettype none
// ============================================================================
// tb_vga_fb_scheduler : directed bench with a 2-cycle SRAM model, 64-pixel frame
// Revision            : 1.0
// ============================================================================
module tb_vga_fb_scheduler;

  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 24;
  localparam int FRAME_PIXELS = 64;
  localparam int FIFO_DEPTH   = 16;
  localparam int RD_LAT       = 2;
  localparam int STARVE_MAX   = 8;

`ifdef STARVE_GUARD_EN
  localparam int EXP_DENIED = STARVE_MAX;
`else
  localparam int EXP_DENIED = FIFO_DEPTH;
`endif

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              pix_ren = 1'b0;
  logic [DATA_W-1:0] pix_data;
  logic              pix_empty;
  logic              underflow;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  vga_fb_scheduler #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FRAME_PIXELS(FRAME_PIXELS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .RD_LAT      (RD_LAT),
    .STARVE_MAX  (STARVE_MAX)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .frame_start(frame_start),
    .pix_ren    (pix_ren),
    .pix_data   (pix_data),
    .pix_empty  (pix_empty),
    .underflow  (underflow),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: data for a read strobed in cycle M is on mem_rdata in cycle M+2.
  logic [DATA_W-1:0] sram [128];
  logic [DATA_W-1:0] rd_s0 = '0;
  logic [DATA_W-1:0] rd_s1 = '0;
  assign mem_rdata = rd_s1;

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr[6:0]] <= mem_wdata;
    rd_s0 <= mem_re ? sram[mem_addr[6:0]] : 24'hDEAD00;
    rd_s1 <= rd_s0;
  end

  function automatic logic [31:0] pat(input int a);
    return 32'h00A50000 | 32'(a);
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_re;
    int denied;
    int granted;
    int idx;
    int reads;
    int last_addr;
    logic ren;

    for (int i = 0; i < 128; i++) sram[i] = pat(i)[DATA_W-1:0];

    // Reset values
    tick();
    tick();
    check_vec("rst_pix_empty", 32'(pix_empty), 32'd1);
    check_vec("rst_underflow", 32'(underflow), 32'd0);
    check_vec("rst_mem_re", 32'(mem_re), 32'd0);
    check_vec("rst_mem_we", 32'(mem_we), 32'd0);
    check_vec("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_vec("rst_pix_data", 32'(pix_data), 32'd0);
    arst_n = 1'b1;
    tick();

    // Frame with no pops: credit limit yields exactly 16 reads at 0..15
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_re = 0;
    for (int c = 0; c < 40; c++) begin
      if (mem_re) begin
        check_vec("fill_addr", 32'(mem_addr), 32'(n_re));
        n_re++;
      end
      tick();
    end
    check_vec("fill_re_count", 32'(n_re), 32'd16);
    check_vec("fill_not_empty", 32'(pix_empty), 32'd0);
    check_vec("fill_head", 32'(pix_data), pat(0));

    // Writer while FIFO full: granted same cycle, memory strobes next cycle
    wr_valid = 1'b1;
    wr_addr  = 19'd100;
    wr_data  = 24'hABCDEF;
    #1;
    check_vec("full_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    check_vec("full_mem_we", 32'(mem_we), 32'd1);
    check_vec("full_mem_re", 32'(mem_re), 32'd0);
    check_vec("full_mem_addr", 32'(mem_addr), 32'd100);
    check_vec("full_mem_wdata", 32'(mem_wdata), 32'h00ABCDEF);
    tick();

    // Fetch priority versus a waiting writer
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 19'd101;
    wr_data  = 24'h123456;
    denied   = 0;
    granted  = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (wr_ready) begin
        granted = 1;
        break;
      end
      denied++;
      tick();
    end
    tick();
    wr_valid = 1'b0;
    check_vec("prio_granted", 32'(granted), 32'd1);
    check_vec("prio_denied_cycles", 32'(denied), 32'(EXP_DENIED));
    check_vec("prio_mem_we", 32'(mem_we), 32'd1);
    check_vec("prio_mem_addr", 32'(mem_addr), 32'd101);
    repeat (5) tick();

    // frame_start with two reads in flight
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    check_vec("stale_pre_re", 32'(mem_re), 32'd1);
    check_vec("stale_pre_addr", 32'(mem_addr), 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_vec("stale_flush_empty", 32'(pix_empty), 32'd1);
    check_vec("stale_no_re", 32'(mem_re), 32'd0);
    tick();
    check_vec("stale_restart_re", 32'(mem_re), 32'd1);
    check_vec("stale_restart_addr", 32'(mem_addr), 32'd0);
    check_vec("stale_empty_a", 32'(pix_empty), 32'd1);
    tick();
    check_vec("stale_empty_b", 32'(pix_empty), 32'd1);
    tick();
    check_vec("stale_empty_c", 32'(pix_empty), 32'd1);
    tick();
    for (int k = 0; k < 6; k++) begin
      check_vec("stale_order_valid", 32'(pix_empty), 32'd0);
      check_vec("stale_order_data", 32'(pix_data), pat(k));
      pix_ren = 1'b1;
      tick();
    end
    pix_ren = 1'b0;

    // Full 64-pixel frame popped every other cycle
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    idx = 0;
    reads = 0;
    last_addr = -1;
    ren = 1'b0;
    for (int c = 0; c < 600 && idx < FRAME_PIXELS; c++) begin
      if (mem_re) begin
        reads++;
        last_addr = int'(mem_addr);
      end
      if (!ren && !pix_empty) begin
        check_vec("frame_pixel", 32'(pix_data), pat(idx));
        ren = 1'b1;
        idx++;
      end else begin
        ren = 1'b0;
      end
      pix_ren = ren;
      tick();
    end
    pix_ren = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (mem_re) reads++;
      tick();
    end
    check_vec("frame_pop_count", 32'(idx), 32'd64);
    check_vec("frame_read_count", 32'(reads), 32'd64);
    check_vec("frame_last_addr", 32'(last_addr), 32'd63);
    check_vec("frame_no_underflow", 32'(underflow), 32'd0);
    check_vec("frame_drained", 32'(pix_empty), 32'd1);
    wr_valid = 1'b1;
    wr_addr  = 19'd102;
    wr_data  = 24'h0F0F0F;
    #1;
    check_vec("done_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;

    // Underflow is sticky across frames until reset
    pix_ren = 1'b1;
    tick();
    pix_ren = 1'b0;
    check_vec("uf_set", 32'(underflow), 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (30) tick();
    check_vec("uf_sticky", 32'(underflow), 32'd1);
    check_vec("uf_frame_fills", 32'(pix_empty), 32'd0);

    // Reset with reads in flight: late returns must not be pushed
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    arst_n = 1'b0;
    #1;
    check_vec("arst_underflow", 32'(underflow), 32'd0);
    check_vec("arst_empty", 32'(pix_empty), 32'd1);
    check_vec("arst_mem_re", 32'(mem_re), 32'd0);
    tick();
    arst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_vec("arst_late_ignored", 32'(pix_empty), 32'd1);
      check_vec("arst_idle_no_re", 32'(mem_re), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
